// File: rtl/test_unit_pkg.sv
// test_unit_pkg: shared state/result encodings and popcount helper for the test-unit sequencer
package test_unit_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SKIP, NEXT, FINISH} seq_state_e;

    typedef enum logic [1:0] {RES_NONE, RES_PASS, RES_FAIL, RES_TMO} unit_res_e;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/test_unit_timer.sv
// test_unit_timer: watchdog counter with clear, enable and terminal-count flag at TIMEOUT_CYC-1
module test_unit_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] cnt;

    // counts cycles spent waiting; clear has priority over enable
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + TW'(1);
    end

    assign tc = cnt == TW'(TIMEOUT_CYC - 1);

endmodule

// File: rtl/test_unit_sequencer.sv
// test_unit_sequencer: launches enabled test units in turn with a watchdog and latches results (option: TEST_UNIT_SEQ_STOP_ON_FAIL_EN)
module test_unit_sequencer
    import test_unit_pkg::*;
#(
    parameter int CH          = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CW         = $clog2(CH + 1),
    localparam int IW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CH-1:0] en_mask,
    input  logic [CH-1:0] unit_done,
    input  logic [CH-1:0] unit_pass,
    output logic [CH-1:0] unit_go,
    output logic          busy,
    output logic          all_done,
    output logic          aborted,
    output logic [IW-1:0] cur_idx,
    output logic [CH-1:0] pass_mask,
    output logic [CH-1:0] fail_mask,
    output logic [CH-1:0] tmo_mask,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt
);
    seq_state_e    state, state_n;
    unit_res_e     res;
    logic [CH-1:0] en_q, en_n, pass_n, fail_n, tmo_n, go_n;
    logic [IW-1:0] idx_n, nxt_idx;
    logic          aborted_n, tmr_tc, stop;

    test_unit_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clock (clock),
        .rst_n (rst_n),
        .clr   (state == LAUNCH),
        .en    (state == WAIT),
        .tc    (tmr_tc)
    );

`ifdef TEST_UNIT_SEQ_STOP_ON_FAIL_EN
    assign stop = (state == NEXT) && fail_mask[cur_idx];
`else
    assign stop = 1'b0;
`endif

    assign busy     = state != IDLE;
    assign all_done = state == FINISH;
    assign nxt_idx  = cur_idx + IW'(1);

    // verdict of the current unit this cycle; a done strobe beats a simultaneous timeout
    always_comb begin
        res = RES_NONE;
        if (state == WAIT)
            res = unit_done[cur_idx] ? (unit_pass[cur_idx] ? RES_PASS : RES_FAIL)
                : tmr_tc ? RES_TMO : RES_NONE;
    end

    // next-state and next-result logic; abort overrides everything outside IDLE
    always_comb begin
        state_n   = state;
        idx_n     = cur_idx;
        en_n      = en_q;
        pass_n    = pass_mask;
        fail_n    = fail_mask;
        tmo_n     = tmo_mask;
        aborted_n = aborted;
        if (abort && state != IDLE) begin
            state_n   = IDLE;
            aborted_n = 1'b1;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    en_n      = en_mask;
                    pass_n    = '0;
                    fail_n    = '0;
                    tmo_n     = '0;
                    aborted_n = 1'b0;
                    idx_n     = '0;
                    state_n   = (en_mask == '0) ? FINISH : en_mask[0] ? LAUNCH : SKIP;
                end
                LAUNCH: state_n = WAIT;
                WAIT: if (res != RES_NONE) begin
                    pass_n[cur_idx] = res == RES_PASS;
                    fail_n[cur_idx] = res != RES_PASS;
                    tmo_n[cur_idx]  = res == RES_TMO;
                    state_n         = NEXT;
                end
                SKIP, NEXT: begin
                    if (cur_idx == IW'(CH - 1) || stop) state_n = FINISH;
                    else begin
                        idx_n   = nxt_idx;
                        state_n = en_q[nxt_idx] ? LAUNCH : SKIP;
                    end
                end
                FINISH: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // the go pulse is registered so it coincides exactly with the LAUNCH cycle
    assign go_n = (state_n == LAUNCH) ? CH'(1) << idx_n : '0;

    // state, index, latched enables, results and their counts
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_idx   <= '0;
            en_q      <= '0;
            pass_mask <= '0;
            fail_mask <= '0;
            tmo_mask  <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            aborted   <= 1'b0;
            unit_go   <= '0;
        end else begin
            state     <= state_n;
            cur_idx   <= idx_n;
            en_q      <= en_n;
            pass_mask <= pass_n;
            fail_mask <= fail_n;
            tmo_mask  <= tmo_n;
            pass_cnt  <= CW'(popcount(32'(pass_n)));
            fail_cnt  <= CW'(popcount(32'(fail_n)));
            aborted   <= aborted_n;
            unit_go   <= go_n;
        end
    end

endmodule
